// File: rtl/top_rx_udiv_26ns_12ns_26_seq.sv
// Receive-side sequential unsigned divider.
// Recovers the unknown factor of a transmit-side product given the known
// factor, one quotient bit per enabled cycle (radix-2 restoring). A nonzero
// remainder marks a corrupted or misaligned word. Operands arrive over
// valid/ready. Results are held until the consumer takes them and stay
// frozen until the next result is produced.
module top_rx_udiv_26ns_12ns_26_seq #(
  parameter int dividend_WIDTH = 26,
  parameter int divisor_WIDTH  = 12
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [dividend_WIDTH-1:0] dividend,
  input  logic [divisor_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [dividend_WIDTH-1:0] quotient,
  output logic [divisor_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int DW = dividend_WIDTH;
  localparam int VW = divisor_WIDTH;
  // The counter only has to reach DW-1, plus one more step on the final edge.
  localparam int CW = (DW > 1) ? $clog2(DW + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Result bundle. It is loaded only on entry to DONE.
  typedef struct packed {
    logic [DW-1:0] quo;
    logic [VW-1:0] rem;
    logic          dbz;
  } res_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;   // dividend bits shift out, quotient bits shift in
  logic [VW:0]   r_q, r_d;           // partial remainder, one guard bit wide
  logic [VW-1:0] dvs_q, dvs_d;
  res_t          res_q, res_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          dvs_zero;
  logic          last_iter;
  logic          load_op;
  logic          load_dbz;
  logic          step;
  logic          finish;

  logic [VW:0]   r_shift;
  logic [VW:0]   r_sub;
  logic          r_ge;
  logic [VW:0]   r_next;
  logic [DW-1:0] shift_next;

  // The guard bit of R is always zero between steps because R < divisor.
  // It is kept so the stored width matches the compare/subtract width.
  logic          unused_r_guard;
  assign unused_r_guard = r_q[VW];

  // Acceptance is gated on the registered ready. This means nothing is taken
  // on the first edge after reset release, and nothing is taken with ce low.
  assign accept    = ce & in_valid & in_ready_q;
  assign dvs_zero  = (divisor == '0);
  assign last_iter = (cnt_q == LAST);

  // One restoring step. Shift the next dividend bit into R, then subtract the
  // divisor when it fits.
  always_comb begin
    r_shift    = {r_q[VW-1:0], shift_q[DW-1]};
    r_sub      = r_shift - {1'b0, dvs_q};
    r_ge       = (r_shift >= {1'b0, dvs_q});
    r_next     = r_ge ? r_sub : r_shift;
    shift_next = {shift_q[DW-2:0], r_ge};
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic. With ce low, every branch holds the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)              state_d = dvs_zero ? S_DONE : S_BUSY;
      S_BUSY: if (ce && last_iter)     state_d = S_DONE;
      S_DONE: if (ce && out_ready)     state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Output and datapath-control decode. The handshake flags are registered
  // copies of the next state, so in_valid and out_ready never reach
  // in_ready or out_valid through combinational logic.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    load_op     = accept & ~dvs_zero;
    load_dbz    = accept &  dvs_zero;
    step        = ce & (state_q == S_BUSY);
    finish      = step & last_iter;
  end

  // Datapath next-state logic.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    if (load_op) begin
      shift_d = dividend;
      dvs_d   = divisor;
      r_d     = '0;
      cnt_d   = '0;
    end else if (step) begin
      shift_d = shift_next;
      r_d     = r_next;
      cnt_d   = CW'(cnt_q + 1'b1);
    end
    if (load_dbz) begin
      // Divide by zero saturates the quotient. The low dividend bits are
      // returned as the remainder so the word can still be inspected.
      res_d.quo = '1;
      res_d.rem = dividend[VW-1:0];
      res_d.dbz = 1'b1;
    end else if (finish) begin
      res_d.quo = shift_next;
      res_d.rem = r_next[VW-1:0];
      res_d.dbz = 1'b0;
    end
  end

  // Datapath and handshake registers. Reset aborts any in-flight operation.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      r_q         <= '0;
      dvs_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      r_q         <= r_d;
      dvs_q       <= dvs_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = res_q.quo;
  assign remainder   = res_q.rem;
  assign div_by_zero = res_q.dbz;

endmodule
